// File: rtl/counter_pkg.sv
// Shared widths, digit type and load clamp helper for the chained digit counter.
// COUNTER_DOWN_EN adds a direction input to the chain; the default build counts up only.
package counter_pkg;

  localparam int unsigned DIGIT_W     = 4;
  localparam int unsigned MAX_MODULUS = 16;
  localparam int unsigned MAX_DIGITS  = 8;

  typedef logic [DIGIT_W-1:0] digit_t;

  // Comparing against modulus-1 keeps the check 4 bits wide, even for modulus 16.
  function automatic digit_t clamp_digit(digit_t value, digit_t max_value);
    return (value > max_value) ? max_value : value;
  endfunction

endpackage

// File: rtl/counter_digit.sv
// One modulo-MODULUS digit: clear, clamped load, step with wrap, terminal flag.
// COUNTER_DOWN_EN adds i_dir, which selects decrement and a zero terminal value.
module counter_digit
  import counter_pkg::*;
#(
  parameter int unsigned MODULUS = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_step,
`ifdef COUNTER_DOWN_EN
  input  logic               i_dir,
`endif
  input  logic               i_load,
  input  logic [DIGIT_W-1:0] i_load_val,
  input  logic               i_clr,
  output logic [DIGIT_W-1:0] o_value,
  output logic               o_term
);

  localparam digit_t MaxVal = digit_t'(MODULUS - 1);

  digit_t r_value;
  digit_t w_value_d;
  digit_t w_next;

  always_comb begin
    w_next = (r_value == MaxVal) ? '0 : r_value + digit_t'(1);
    o_term = (r_value == MaxVal);
`ifdef COUNTER_DOWN_EN
    if (i_dir) begin
      w_next = (r_value == '0) ? MaxVal : r_value - digit_t'(1);
      o_term = (r_value == '0);
    end
`endif
  end

  always_comb begin
    w_value_d = r_value;
    if (i_clr) begin
      w_value_d = '0;
    end else if (i_load) begin
      w_value_d = clamp_digit(i_load_val, MaxVal);
    end else if (i_step) begin
      w_value_d = w_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_value <= '0;
    end else begin
      r_value <= w_value_d;
    end
  end

  assign o_value = r_value;

endmodule

// File: rtl/bcd_chain_counter.sv
// Multi-digit modulo counter: ripple-carry step chain, terminal flag and wrap pulse.
// Define COUNTER_DOWN_EN to add the i_dir port (1 = count down with borrow).
module bcd_chain_counter
  import counter_pkg::*;
#(
  parameter int unsigned DIGITS  = 4,
  parameter int unsigned MODULUS = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_clk_en,
  input  logic                      i_inc,
  input  logic                      i_clr,
  input  logic                      i_load,
  input  logic [DIGIT_W*DIGITS-1:0] i_load_val,
`ifdef COUNTER_DOWN_EN
  input  logic                      i_dir,
`endif
  output logic [DIGIT_W*DIGITS-1:0] o_cnt_out,
  output logic                      o_co,
  output logic                      o_ovf
);

  logic              w_count;
  logic [DIGITS-1:0] w_step;
  logic [DIGITS-1:0] w_term;
  logic              w_ovf_d;
  logic              r_ovf;

  assign w_count = i_clk_en & i_inc;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    // Each step is formed from the raw term flags, so every digit updates on the same edge.
    if (g == 0) begin : g_first
      assign w_step[g] = w_count;
    end else begin : g_rest
      assign w_step[g] = w_count & (&w_term[g-1:0]);
    end

    counter_digit #(
      .MODULUS(MODULUS)
    ) u_digit (
      .clk       (clk),
      .rst       (rst),
      .i_step    (w_step[g]),
`ifdef COUNTER_DOWN_EN
      .i_dir     (i_dir),
`endif
      .i_load    (i_load),
      .i_load_val(i_load_val[g*DIGIT_W +: DIGIT_W]),
      .i_clr     (i_clr),
      .o_value   (o_cnt_out[g*DIGIT_W +: DIGIT_W]),
      .o_term    (w_term[g])
    );
  end

  assign o_co = &w_term;

  // A wrap is a count taken at terminal count; clr and load both take priority over it.
  assign w_ovf_d = ~i_clr & ~i_load & w_count & o_co;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else begin
      r_ovf <= w_ovf_d;
    end
  end

  assign o_ovf = r_ovf;

endmodule
